// File: rtl/vs10xx_spi_ctrl.sv
// VS10xx decoder SPI controller: hardware reset/init sequencing, SCI register writes, DREQ-gated SDI bursts.
// Define VS10XX_VOLUME_EN to add the vol input that is mirrored automatically into SCI VOL (0x0B).
module vs10xx_spi_ctrl #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned BURST_BYTES  = 32,
  parameter int unsigned RESET_CYCLES = 1000,
  parameter int unsigned INIT_WAIT    = 2000,
  parameter logic [15:0] INIT_MODE    = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DREQ,
  output logic        xRSET,
  output logic        XCS,
  output logic        XDCS,
  output logic        SI,
  output logic        SCLK,
  input  logic        sci_req,
  input  logic [7:0]  sci_addr,
  input  logic [15:0] sci_wdata,
  output logic        sci_ack,
  input  logic [7:0]  sdi_data,
  input  logic        sdi_valid,
  output logic        sdi_ready,
`ifdef VS10XX_VOLUME_EN
  input  logic [7:0]  vol,
`endif
  output logic        init_done,
  output logic        busy
);

  localparam int unsigned MAX_WAIT = (RESET_CYCLES > INIT_WAIT) ? RESET_CYCLES : INIT_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned BYTE_W   = $clog2(BURST_BYTES + 1);
  localparam int unsigned HALF_W   = 7;

  localparam logic [2:0] ST_HW_RESET = 3'd0;
  localparam logic [2:0] ST_HW_WAIT  = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_SCI      = 3'd4;
  localparam logic [2:0] ST_SDI      = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d, half_nx, last_half;
  logic [31:0]       shift_q, shift_d;
  logic [BYTE_W-1:0] bytes_q, bytes_d;
  logic xrset_q, xrset_d, xcs_q, xcs_d, xdcs_q, xdcs_d, sclk_q, sclk_d;
  logic ack_q, ack_d, ready_q, ready_d, init_done_q, init_done_d, busy_q, busy_d;
  logic ack_en_q, ack_en_d;
`ifdef VS10XX_VOLUME_EN
  logic [7:0] vol_shadow_q, vol_shadow_d, vol_pend_q, vol_pend_d;
`endif

  // Next-state and output decode; half_q counts SCLK half-periods since frame start.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    half_d      = half_q;
    shift_d     = shift_q;
    bytes_d     = bytes_q;
    xcs_d       = xcs_q;
    xdcs_d      = xdcs_q;
    sclk_d      = sclk_q;
    ack_d       = 1'b0;
    ready_d     = 1'b0;
    init_done_d = init_done_q;
    ack_en_d    = ack_en_q;
`ifdef VS10XX_VOLUME_EN
    vol_shadow_d = vol_shadow_q;
    vol_pend_d   = vol_pend_q;
`endif
    half_nx   = half_q + HALF_W'(1);
    last_half = (state_q == ST_SDI) ? HALF_W'(16) : HALF_W'(64);
    case (state_q)
      ST_HW_RESET: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = ST_HW_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HW_WAIT: begin
        if (cnt_q < CNT_W'(INIT_WAIT - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (DREQ) begin
          state_d = ST_INIT;
          xcs_d   = 1'b0;
          shift_d = {8'h02, 8'h00, INIT_MODE};
          div_d   = '0;
          half_d  = '0;
        end
      end
      ST_IDLE: begin
        div_d  = '0;
        half_d = '0;
        if (DREQ && sci_req) begin
          state_d  = ST_SCI;
          ack_en_d = 1'b1;
          xcs_d    = 1'b0;
          shift_d  = {8'h02, sci_addr, sci_wdata};
        end
`ifdef VS10XX_VOLUME_EN
        else if (DREQ && (vol != vol_shadow_q)) begin
          state_d    = ST_SCI;
          ack_en_d   = 1'b0;
          xcs_d      = 1'b0;
          shift_d    = {8'h02, 8'h0B, vol, vol};
          vol_pend_d = vol;
        end
`endif
        else if (DREQ && sdi_valid) begin
          state_d = ST_SDI;
          xdcs_d  = 1'b0;
          ready_d = 1'b1;
          bytes_d = BYTE_W'(1);
          shift_d = {sdi_data, 24'h000000};
        end
      end
      ST_INIT, ST_SCI, ST_SDI: begin
        if (half_q == last_half + HALF_W'(1)) begin
          state_d = ST_IDLE;
        end else if (div_q != DIV_W'(CLK_DIV - 1)) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d  = '0;
          half_d = half_nx;
          if (half_nx == last_half + HALF_W'(1)) begin
            xcs_d  = 1'b1;
            xdcs_d = 1'b1;
            if (state_q == ST_INIT) init_done_d = 1'b1;
            if (state_q == ST_SCI) begin
              ack_d = ack_en_q;
`ifdef VS10XX_VOLUME_EN
              if (!ack_en_q) vol_shadow_d = vol_pend_q;
`endif
            end
          end else if (half_nx[0]) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Next SDI byte is chained on the last falling edge so SCLK never gaps.
            if ((state_q == ST_SDI) && (half_nx == last_half) && sdi_valid &&
                (bytes_q < BYTE_W'(BURST_BYTES))) begin
              shift_d = {sdi_data, 24'h000000};
              ready_d = 1'b1;
              half_d  = '0;
              bytes_d = bytes_q + BYTE_W'(1);
            end else begin
              shift_d = {shift_q[30:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_HW_RESET;
    endcase
    xrset_d = (state_d != ST_HW_RESET);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HW_RESET;
      cnt_q       <= '0;
      div_q       <= '0;
      half_q      <= '0;
      shift_q     <= '0;
      bytes_q     <= '0;
      xrset_q     <= 1'b0;
      xcs_q       <= 1'b1;
      xdcs_q      <= 1'b1;
      sclk_q      <= 1'b0;
      ack_q       <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      ack_en_q    <= 1'b1;
`ifdef VS10XX_VOLUME_EN
      vol_shadow_q <= 8'h00;
      vol_pend_q   <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      bytes_q     <= bytes_d;
      xrset_q     <= xrset_d;
      xcs_q       <= xcs_d;
      xdcs_q      <= xdcs_d;
      sclk_q      <= sclk_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      ack_en_q    <= ack_en_d;
`ifdef VS10XX_VOLUME_EN
      vol_shadow_q <= vol_shadow_d;
      vol_pend_q   <= vol_pend_d;
`endif
    end
  end

  assign xRSET     = xrset_q;
  assign XCS       = xcs_q;
  assign XDCS      = xdcs_q;
  assign SI        = shift_q[31];
  assign SCLK      = sclk_q;
  assign sci_ack   = ack_q;
  assign sdi_ready = ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vs10xx_spi_ctrl.sv
// Self-checking bench for vs10xx_spi_ctrl: a pin-level SPI monitor decodes frames and timing,
// and each test compares them against expectations derived from the decoder protocol.
module tb_vs10xx_spi_ctrl;
  localparam int TB_DIV   = 2;
  localparam int TB_BURST = 32;
  localparam int TB_RST   = 10;
  localparam int TB_WAIT  = 20;

  logic clk = 1'b0, rst = 1'b1, DREQ = 1'b1, sci_req = 1'b0, sdi_valid = 1'b0;
  logic [7:0]  sci_addr = 8'h00, sdi_data = 8'h00;
  logic [15:0] sci_wdata = 16'h0000;
  logic xRSET, XCS, XDCS, SI, SCLK, sci_ack, sdi_ready, init_done, busy;
`ifdef VS10XX_VOLUME_EN
  logic [7:0] vol = 8'h00;
`endif

  int checks = 0, errors = 0, cyc = 0;

  vs10xx_spi_ctrl #(.CLK_DIV(TB_DIV), .BURST_BYTES(TB_BURST), .RESET_CYCLES(TB_RST),
                    .INIT_WAIT(TB_WAIT), .INIT_MODE(16'h0800)) dut (
    .clk(clk), .rst(rst), .DREQ(DREQ), .xRSET(xRSET), .XCS(XCS), .XDCS(XDCS), .SI(SI),
    .SCLK(SCLK), .sci_req(sci_req), .sci_addr(sci_addr), .sci_wdata(sci_wdata),
    .sci_ack(sci_ack), .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
`ifdef VS10XX_VOLUME_EN
    .vol(vol),
`endif
    .init_done(init_done), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream byte source: presents src[0] while non-empty, pops on a valid&ready cycle.
  logic [7:0] src[$];
  bit hs;
  always begin
    @(posedge clk);
    hs = sdi_valid && sdi_ready;
    #1;
    if (hs && src.size() > 0) void'(src.pop_front());
    sdi_valid = (src.size() > 0);
    sdi_data  = (src.size() > 0) ? src[0] : 8'h00;
  end

  // Pin monitor: decodes frames and flags any deviation from the mode-0 timing rules.
  bit          fr_sci[$], fr_ok[$];
  int          fr_start[$], fr_end[$], fr_nbits[$], fr_nbytes[$];
  logic [31:0] fr_word[$];
  logic [7:0]  sdi_bytes[$];
  int          ack_cyc[$];
  int ready_cnt = 0, overlap_cnt = 0, stray_cnt = 0, xrset_rise = -1, idone_rise = -1;
  int m_start = 0, m_nbits = 0, m_nbytes = 0, m_last_end = -100;
  bit m_ok = 1'b0, m_sci = 1'b0, cs_now, cs_prev = 1'b0, sclk_prev = 1'b0, si_prev = 1'b0;
  bit xrset_prev = 1'b0, idone_prev = 1'b0;
  logic [31:0] m_word = '0;

  always @(negedge clk) begin
    cs_now = (XCS === 1'b0) || (XDCS === 1'b0);
    if (XCS === 1'b0 && XDCS === 1'b0) overlap_cnt++;
    if (xRSET === 1'b1 && !xrset_prev) xrset_rise = cyc;
    if (init_done === 1'b1 && !idone_prev) idone_rise = cyc;
    if (sci_ack === 1'b1) ack_cyc.push_back(cyc);
    if (sdi_ready === 1'b1) ready_cnt++;
    if (cs_now && !cs_prev) begin
      m_start = cyc; m_nbits = 0; m_nbytes = 0; m_word = '0;
      m_ok = (cyc >= m_last_end + 2); m_sci = (XCS === 1'b0);
    end
    if (cs_now) begin
      if (SCLK === 1'b1 && !sclk_prev) begin
        if (cyc != m_start + (2 * m_nbits + 1) * TB_DIV) m_ok = 1'b0;
        m_word = {m_word[30:0], SI};
        m_nbits++;
        if (!m_sci && (m_nbits % 8 == 0)) begin
          sdi_bytes.push_back(m_word[7:0]);
          m_nbytes++;
        end
      end else if (SCLK === 1'b0 && sclk_prev) begin
        if (cyc != m_start + 2 * m_nbits * TB_DIV) m_ok = 1'b0;
      end else if (SCLK === 1'b1 && SI !== si_prev) begin
        m_ok = 1'b0;
      end
    end else if (SCLK === 1'b1) begin
      stray_cnt++;
    end
    if (!cs_now && cs_prev) begin
      if (cyc != m_start + (2 * m_nbits + 1) * TB_DIV) m_ok = 1'b0;
      fr_sci.push_back(m_sci); fr_ok.push_back(m_ok); fr_start.push_back(m_start);
      fr_end.push_back(cyc); fr_nbits.push_back(m_nbits); fr_nbytes.push_back(m_nbytes);
      fr_word.push_back(m_word);
      m_last_end = cyc;
    end
    cs_prev = cs_now; sclk_prev = (SCLK === 1'b1); si_prev = (SI === 1'b1);
    xrset_prev = (xRSET === 1'b1); idone_prev = (init_done === 1'b1);
  end

  task automatic wait_quiet(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (src.size() == 0 && !sdi_valid && !busy && !sci_req) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_init(input string tag, input int c_rel);
    int fr0;
    fr0 = fr_sci.size();
    for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || fr_sci.size() != fr0 + 1) begin
      errors++; $display("FAIL %s_init_frame init_done=%b frames=%0d required 1", tag, init_done, fr_sci.size() - fr0);
      return;
    end
    checks++;
    if (xrset_rise != c_rel + TB_RST) begin
      errors++; $display("FAIL %s_xrset_low got_rise=%0d required=%0d", tag, xrset_rise, c_rel + TB_RST);
    end
    checks++;
    if (fr_start[fr0] != xrset_rise + TB_WAIT) begin
      errors++; $display("FAIL %s_xcs_fall got=%0d required=%0d", tag, fr_start[fr0], xrset_rise + TB_WAIT);
    end
    checks++;
    if (!fr_sci[fr0] || fr_word[fr0] !== 32'h02000800 || fr_nbits[fr0] != 32 || !fr_ok[fr0]) begin
      errors++; $display("FAIL %s_init_word got=%h sci=%0b bits=%0d ok=%0b required=02000800", tag, fr_word[fr0], fr_sci[fr0], fr_nbits[fr0], fr_ok[fr0]);
    end
    checks++;
    if (idone_rise != fr_start[fr0] + 65 * TB_DIV) begin
      errors++; $display("FAIL %s_init_done_time got=%0d required=%0d", tag, idone_rise, fr_start[fr0] + 65 * TB_DIV);
    end
  endtask

  task automatic test_reset();
    int c_rel, ack0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({xRSET, XCS, XDCS, SI, SCLK, sci_ack, sdi_ready, init_done, busy} !== 9'b011000001) begin
      errors++; $display("FAIL reset_values got=%b required=011000001", {xRSET, XCS, XDCS, SI, SCLK, sci_ack, sdi_ready, init_done, busy});
    end
    ack0 = ack_cyc.size();
    c_rel = cyc;
    rst = 1'b0;
    test_init("reset", c_rel);
    checks++;
    if (ack_cyc.size() != ack0) begin
      errors++; $display("FAIL init_no_ack got=%0d acks required=0", ack_cyc.size() - ack0);
    end
  endtask

  task automatic test_sci(input int n);
    logic [7:0] a; logic [15:0] d; int fr0, ack0; bit got;
    for (int k = 0; k < n; k++) begin
      a = (k == 0) ? 8'h03 : 8'($urandom);
      d = (k == 0) ? 16'h9800 : 16'($urandom);
      fr0 = fr_sci.size(); ack0 = ack_cyc.size();
      @(negedge clk);
      sci_addr = a; sci_wdata = d; sci_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (sci_ack === 1'b1) begin got = 1'b1; break; end
      end
      sci_req = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (!got || fr_sci.size() != fr0 + 1 || ack_cyc.size() != ack0 + 1) begin
        errors++; $display("FAIL sci_handshake ack_seen=%0b frames=%0d acks=%0d required 1/1/1", got, fr_sci.size() - fr0, ack_cyc.size() - ack0);
        continue;
      end
      checks++;
      if (!fr_sci[fr0] || fr_word[fr0] !== {8'h02, a, d} || fr_nbits[fr0] != 32 || !fr_ok[fr0]) begin
        errors++; $display("FAIL sci_frame got=%h ok=%0b required=%h", fr_word[fr0], fr_ok[fr0], {8'h02, a, d});
      end
      checks++;
      if (ack_cyc[ack0] != fr_start[fr0] + 65 * TB_DIV) begin
        errors++; $display("FAIL sci_ack_time got=%0d required=%0d", ack_cyc[ack0], fr_start[fr0] + 65 * TB_DIV);
      end
    end
  endtask

  task automatic test_sdi_burst(input int n, input bit seq);
    logic [7:0] exp[$]; logic [7:0] b; int fr0, b0, r0, nfr, sz, bad; bit ok;
    fr0 = fr_sci.size(); b0 = sdi_bytes.size(); r0 = ready_cnt;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      exp.push_back(b); src.push_back(b);
    end
    wait_quiet(n * 40 + 200, ok);
    nfr = (n + TB_BURST - 1) / TB_BURST;
    checks++;
    if (!ok || fr_sci.size() != fr0 + nfr) begin
      errors++; $display("FAIL sdi_burst_count n=%0d done=%0b got=%0d required=%0d", n, ok, fr_sci.size() - fr0, nfr);
      return;
    end
    for (int f = 0; f < nfr; f++) begin
      sz = (n - f * TB_BURST > TB_BURST) ? TB_BURST : n - f * TB_BURST;
      checks++;
      if (fr_sci[fr0 + f] || fr_nbytes[fr0 + f] != sz || !fr_ok[fr0 + f]) begin
        errors++; $display("FAIL sdi_burst_shape burst=%0d got_bytes=%0d ok=%0b sci=%0b required=%0d", f, fr_nbytes[fr0 + f], fr_ok[fr0 + f], fr_sci[fr0 + f], sz);
      end
    end
    bad = 0;
    for (int i = 0; i < n; i++) if (sdi_bytes.size() <= b0 + i || sdi_bytes[b0 + i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || ready_cnt - r0 != n) begin
      errors++; $display("FAIL sdi_bytes mismatched=%0d ready_pulses=%0d required 0/%0d", bad, ready_cnt - r0, n);
    end
  endtask

  task automatic test_dreq_gate();
    logic [7:0] a; logic [15:0] d; logic [7:0] b[3]; int fr0, r0, b0; bit ok;
    a = 8'($urandom); d = 16'($urandom);
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    fr0 = fr_sci.size(); r0 = ready_cnt; b0 = sdi_bytes.size();
    @(negedge clk);
    DREQ = 1'b0; sci_addr = a; sci_wdata = d; sci_req = 1'b1;
    for (int i = 0; i < 3; i++) src.push_back(b[i]);
    repeat (60) @(negedge clk);
    checks++;
    if (fr_sci.size() != fr0 || ready_cnt != r0 || XCS !== 1'b1 || XDCS !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dreq_low_idle frames=%0d ready=%0d XCS=%b XDCS=%b busy=%b required 0/0/1/1/0", fr_sci.size() - fr0, ready_cnt - r0, XCS, XDCS, busy);
    end
    DREQ = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sci_ack === 1'b1) begin ok = 1'b1; break; end
    end
    sci_req = 1'b0;
    wait_quiet(400, ok);
    checks++;
    if (!ok || fr_sci.size() != fr0 + 2) begin
      errors++; $display("FAIL dreq_release_frames done=%0b got=%0d required=2", ok, fr_sci.size() - fr0);
      return;
    end
    checks++;
    if (!fr_sci[fr0] || fr_word[fr0] !== {8'h02, a, d} || fr_sci[fr0 + 1] || fr_nbytes[fr0 + 1] != 3 ||
        sdi_bytes[b0] !== b[0] || sdi_bytes[b0 + 1] !== b[1] || sdi_bytes[b0 + 2] !== b[2]) begin
      errors++; $display("FAIL sci_priority first_sci=%0b word=%h second_sci=%0b bytes=%0d required 1/%h/0/3", fr_sci[fr0], fr_word[fr0], fr_sci[fr0 + 1], fr_nbytes[fr0 + 1], {8'h02, a, d});
    end
  endtask

  task automatic test_dreq_midburst();
    int fr0; bit ok;
    fr0 = fr_sci.size();
    @(negedge clk);
    for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 50 && XDCS !== 1'b0; i++) @(negedge clk);
    DREQ = 1'b0;
    wait_quiet(1000, ok);
    DREQ = 1'b1;
    checks++;
    if (!ok || fr_sci.size() != fr0 + 1 || fr_nbytes[fr0] != 12 || !fr_ok[fr0]) begin
      errors++; $display("FAIL dreq_midburst done=%0b frames=%0d required one 12-byte burst", ok, fr_sci.size() - fr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a; logic [15:0] d; int fr0; bit ok;
    a = 8'($urandom); d = 16'($urandom);
    fr0 = fr_sci.size();
    @(negedge clk);
    for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 50 && XDCS !== 1'b0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    sci_addr = a; sci_wdata = d; sci_req = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (sci_ack === 1'b1) break;
    end
    sci_req = 1'b0;
    wait_quiet(400, ok);
    checks++;
    if (!ok || fr_sci.size() != fr0 + 2) begin
      errors++; $display("FAIL b2b_frames done=%0b got=%0d required=2", ok, fr_sci.size() - fr0);
      return;
    end
    checks++;
    if (fr_sci[fr0] || fr_nbytes[fr0] != 20 || !fr_sci[fr0 + 1] || fr_word[fr0 + 1] !== {8'h02, a, d} || !fr_ok[fr0 + 1]) begin
      errors++; $display("FAIL sci_waits_burst bytes=%0d word=%h required 20/%h", fr_nbytes[fr0], fr_word[fr0 + 1], {8'h02, a, d});
    end
  endtask

  task automatic test_rst_mid();
    int c_rel;
    @(negedge clk);
    for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 50 && XDCS !== 1'b0; i++) @(negedge clk);
    repeat (3 * TB_DIV) @(negedge clk);
    for (int i = 0; i < 10 && SCLK !== 1'b1; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({xRSET, XCS, XDCS, SI, SCLK, sci_ack, sdi_ready, init_done, busy} !== 9'b011000001) begin
      errors++; $display("FAIL rst_mid_values got=%b required=011000001", {xRSET, XCS, XDCS, SI, SCLK, sci_ack, sdi_ready, init_done, busy});
    end
    src.delete();
    c_rel = cyc;
    rst = 1'b0;
    @(negedge clk);
    test_init("restart", c_rel);
  endtask

`ifdef VS10XX_VOLUME_EN
  task automatic test_volume();
    int fr0, ack0; bit ok;
    fr0 = fr_sci.size(); ack0 = ack_cyc.size();
    @(negedge clk);
    vol = 8'h20;
    repeat (10) @(negedge clk);
    wait_quiet(400, ok);
    checks++;
    if (!ok || fr_sci.size() != fr0 + 1 || fr_word[fr0] !== 32'h020B2020 || ack_cyc.size() != ack0) begin
      errors++; $display("FAIL volume_write frames=%0d acks=%0d required one frame 020B2020 without ack", fr_sci.size() - fr0, ack_cyc.size() - ack0);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (fr_sci.size() != fr0 + 1) begin
      errors++; $display("FAIL volume_steady frames=%0d required=1", fr_sci.size() - fr0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sci(4);
    test_sdi_burst(40, 1'b1);
    test_sdi_burst(int'($urandom_range(1, 70)), 1'b0);
    test_dreq_gate();
    test_dreq_midburst();
    test_back_to_back();
    test_rst_mid();
`ifdef VS10XX_VOLUME_EN
    test_volume();
`endif
    checks++;
    if (overlap_cnt != 0 || stray_cnt != 0) begin
      errors++; $display("FAIL bus_hygiene overlap=%0d stray_sclk=%0d required 0/0", overlap_cnt, stray_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vs10xx_spi_ctrl.md
# vs10xx_spi_ctrl

Parametrised SPI controller for the VS10xx MP3 decoder chip; successor to the fixed single-purpose MP3 driver. Sequences the hardware reset and init of the decoder, performs arbitrary SCI register writes on request, and streams audio bytes from an upstream valid/ready source over SDI in DREQ-gated bursts. Sits between the audio/ROM fetch logic and the decoder pins at top level.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles (≥2)
- BURST_BYTES, 32: maximum SDI bytes per DREQ-gated burst (1..32)
- RESET_CYCLES, 1000: clk cycles xRSET held low during hardware reset
- INIT_WAIT, 2000: clk cycles after xRSET release before DREQ is sampled
- INIT_MODE, 16'h0800: value written to SCI MODE (addr 0x00) during init
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- DREQ  in  1  decoder data request; high = ready for SCI or ≥32 SDI bytes
- xRSET  out  1  decoder hardware reset, active low
- XCS  out  1  SCI chip select, active low
- XDCS  out  1  SDI chip select, active low
- SI  out  1  serial data to decoder, MSB first
- SCLK  out  1  serial clock, idle low (SPI mode 0)
- sci_req  in  1  level request for SCI write; hold until sci_ack
- sci_addr  in  8  SCI register address
- sci_wdata  in  16  SCI register data
- sci_ack  out  1  one-cycle pulse when SCI write completes
- sdi_data  in  8  audio byte
- sdi_valid  in  1  sdi_data valid
- sdi_ready  out  1  one-cycle pulse: byte accepted this cycle
- init_done  out  1  high once init sequence finished
- busy  out  1  high in any state except IDLE

## Operation
- States: HW_RESET → HW_WAIT → INIT_SCI → IDLE ⇄ {SCI_XFER, SDI_BURST}.
- HW_RESET: xRSET=0 for RESET_CYCLES, then HW_WAIT.
- HW_WAIT: xRSET=1; count INIT_WAIT, then wait DREQ=1; go INIT_SCI.
- INIT_SCI: one SCI write of INIT_MODE to 0x00; on completion init_done=1, go IDLE.
- IDLE: only leaves when DREQ=1. sci_req has priority over sdi_valid when both high.
- SCI_XFER: XCS low; shifts 32 bits {8'h02, sci_addr, sci_wdata}; sci_ack on completion; return IDLE.
- SDI_BURST: XDCS low; shift byte; before each next byte, if sdi_valid=1 and count<BURST_BYTES, load it (sdi_ready pulse) and continue; otherwise deassert XDCS, return IDLE. DREQ not re-sampled mid-burst.
- A pending sci_req during SDI_BURST waits for burst end; never interrupts a byte.
- rst at any time: all outputs to reset values next edge, state HW_RESET, byte counter cleared; partial SPI frames abandoned.
- Reset values: xRSET=0, XCS=1, XDCS=1, SI=0, SCLK=0, sci_ack=0, sdi_ready=0, init_done=0, busy=1.

## Timing
- Frame start (cycle 0): chip select falls, SI = MSB.
- Bit n: SCLK rises at cycle (2n+1)·CLK_DIV, falls at (2n+2)·CLK_DIV; SI updates on same cycle as falling edge.
- SCI frame: last fall at 64·CLK_DIV; XCS rises and sci_ack pulses at 65·CLK_DIV; IDLE next cycle.
- SDI: bytes back-to-back with no SCLK gap; sdi_ready pulses in the cycle byte is loaded (cycle 0 for first, at falling edge of previous bit 0 for next). XDCS rises CLK_DIV cycles after final falling edge.
- Minimum one IDLE cycle between any two frames; XCS and XDCS never low simultaneously.
- Byte count width: $clog2(BURST_BYTES+1); saturates, no wrap.

## Configuration
- VS10XX_VOLUME_EN defined: adds input vol[7:0]; a shadow register holds the last written value (reset 8'h00, not written at init). In IDLE with DREQ=1, if vol ≠ shadow and sci_req=0, performs internal SCI write {0x02, 0x0B, vol, vol} without sci_ack, then updates shadow. Priority: sci_req > volume > SDI.
- Not defined: no vol port, no automatic writes.

## Test plan
- Reset/init, CLK_DIV=2, RESET_CYCLES=10, INIT_WAIT=20, DREQ=1 → xRSET low 10 cycles, first XCS fall after 20 more, SI bits 0x02000800, init_done=1 after XCS rise.
- sci_req addr 0x03 data 0x9800 → SI frame 0x02039800, sci_ack one pulse at frame+65·CLK_DIV, XDCS stays 1.
- sdi_valid held high, 40 bytes 0x00..0x27, DREQ=1 → burst of 32 bytes under one XDCS low, XDCS high, second burst of 8; 40 sdi_ready pulses.
- DREQ=0 in IDLE with sci_req and sdi_valid high → no chip-select activity; raising DREQ → SCI frame first, then SDI.
- rst asserted mid SDI byte → next edge XDCS=1, SCLK=0, xRSET=0, init_done=0; sequence restarts.
- VS10XX_VOLUME_EN, vol 0x00→0x20 in IDLE → frame 0x020B2020, no sci_ack; unchanged vol → no further frames.
